mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage between the execute stage and the writeback stage of the in-order RISC-V core. It issues loads and stores to the data memory over a req/gnt/rvalid bus, aligns and sign-extends load data, and stalls upstream while an access is outstanding. Its registered result bundle (rf write controls, ALU result, load data, mem_to_reg select, staller flag) is what writeback consumes.

Parameters:
ALEN, 32, data/address width; only 32 is supported.
RADDR_W, 5, register-file address width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_valid  in  1  execute stage presents an instruction
i_rf_wr  in  1  instruction writes the register file
i_rf_wr_addr  in  RADDR_W  destination register
i_alu_res  in  ALEN  ALU result; effective address for load/store
i_mem_rd  in  1  load
i_mem_wr  in  1  store; never high together with i_mem_rd
i_funct3  in  3  access size and sign (RV32I encoding)
i_store_data  in  ALEN  rs2 value for stores
o_stall  out  1  hold the execute stage and all earlier stages
o_dmem_req  out  1  bus request
o_dmem_we  out  1  1 = store
o_dmem_be  out  4  byte enables
o_dmem_addr  out  ALEN  word-aligned address, {i_alu_res[31:2],2'b00}
o_dmem_wdata  out  ALEN  lane-replicated store data
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  load data valid
i_dmem_rdata  in  ALEN  load data word
o_rf_wr  out  1  to writeback
o_rf_wr_addr  out  RADDR_W  to writeback
o_rf_wr_data  out  ALEN  registered ALU result
o_mem_to_reg  out  1  writeback selects o_mem_data
o_mem_data  out  ALEN  aligned, extended load data
o_staller  out  1  registered: the retiring instruction was a load
o_fault  out  1  registered one-cycle pulse: misaligned access or illegal funct3

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM to IDLE; every registered output (o_rf_wr, o_rf_wr_addr, o_rf_wr_data, o_mem_to_reg, o_mem_data, o_staller, o_fault) is 0; o_dmem_req=0; o_stall=0 while in reset.
- FSM states: IDLE, REQ (request held, awaiting gnt), RESP (load granted, awaiting rvalid).
- IDLE: if i_valid and a mem op and no fault, drive req/we/be/addr/wdata combinationally from the inputs. On gnt: a store completes in that cycle; a load goes to RESP. Without gnt, go to REQ and latch the request. A rvalid arriving in the same cycle as gnt is illegal on this bus; rvalid comes no earlier than the cycle after gnt.
- REQ: re-drive the latched request unchanged until gnt. Store with gnt goes to IDLE (complete). Load with gnt goes to RESP.
- RESP: o_dmem_req=0. On rvalid, the load completes and the FSM goes to IDLE.
- o_stall = access in flight AND not completing this cycle. It is combinational, so upstream advances in the cycle a store is granted or load data returns.
- Output register update each edge:
  - On completion, or on an accepted non-mem instruction: load the instruction's fields.
  - Otherwise (stall cycle, or i_valid=0): insert a bubble, all outputs 0. This prevents duplicate writeback.
  - Non-mem instruction latency: 1 cycle. Load: result is registered the edge after rvalid. o_staller=1 only for a completed load.
- Load extract: byte lane = addr[1:0] as latched at issue. funct3 000 LB and 100 LBU select the lane byte; 001 LH and 101 LHU select the half at addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; 010 LW passes the word through.
- Store: SB gives be=0001<<addr[1:0] and wdata={4{d[7:0]}}. SH gives be=0011<<{addr[1],1'b0} and wdata={2{d[15:0]}}. SW gives be=1111.
- Fault conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - funct3 011/110/111 on any mem op.
  - On fault: no request is issued, no stall, o_rf_wr=0, o_fault=1 for one cycle, o_mem_to_reg=0.
- Reset mid-operation returns the FSM to IDLE at once. A late rvalid/gnt arriving in IDLE with no request outstanding is ignored.
- Completion and a new upstream instruction never overlap, because upstream is held by o_stall until the completion cycle.

Test Plan:
- ADD x5 result 0x1234 (i_rf_wr=1, no mem) -> next cycle o_rf_wr=1, o_rf_wr_addr=5, o_rf_wr_data=0x1234, o_mem_to_reg=0, o_stall never high.
- LB addr 0x103, gnt immediate, rvalid 2 cycles later with rdata 0x80AABBCC -> o_stall high 2 cycles; then o_mem_data=0xFFFFFF80, o_mem_to_reg=1, o_staller=1 for 1 cycle; bubbles during stall.
- SH addr 0x202, data 0x0000BEEF, gnt delayed 3 cycles -> req/be=1100/wdata=0xBEEFBEEF/addr=0x200 stable for 4 cycles; completes on gnt; o_rf_wr=0.
- LW addr 0x101 -> o_dmem_req stays 0, o_fault pulses 1 cycle, o_rf_wr=0, no stall.
- LHU addr 0x106, rdata 0xF00D1234 -> o_mem_data=0x0000F00D.
- Assert rst_n=0 while in RESP, then rvalid after release -> outputs 0, FSM IDLE, stray rvalid produces no writeback.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage between execute and writeback.
// Drives the req/gnt/rvalid bus, aligns load data, stalls upstream.
module mem_stage #(
  parameter int ALEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic               i_rf_wr,
  input  logic [RADDR_W-1:0] i_rf_wr_addr,
  input  logic [ALEN-1:0]    i_alu_res,
  input  logic               i_mem_rd,
  input  logic               i_mem_wr,
  input  logic [2:0]         i_funct3,
  input  logic [ALEN-1:0]    i_store_data,
  output logic               o_stall,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [3:0]         o_dmem_be,
  output logic [ALEN-1:0]    o_dmem_addr,
  output logic [ALEN-1:0]    o_dmem_wdata,
  input  logic               i_dmem_gnt,
  input  logic               i_dmem_rvalid,
  input  logic [ALEN-1:0]    i_dmem_rdata,
  output logic               o_rf_wr,
  output logic [RADDR_W-1:0] o_rf_wr_addr,
  output logic [ALEN-1:0]    o_rf_wr_data,
  output logic               o_mem_to_reg,
  output logic [ALEN-1:0]    o_mem_data,
  output logic               o_staller,
  output logic               o_fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nxt;

  logic               mem_op, bad_f3, misal, fault;
  logic               issue, busy, st_done, ld_done, done;
  logic               in_idle, nonmem;
  logic [3:0]         be_in;
  logic [ALEN-1:0]    wdata_in, addr_in;

  logic               l_we, l_rf_wr;
  logic [3:0]         l_be;
  logic [1:0]         l_off;
  logic [2:0]         l_f3;
  logic [RADDR_W-1:0] l_rd;
  logic [ALEN-1:0]    l_addr, l_wdata, l_alu;

  logic [ALEN-1:0]    sh, ld_data;
  logic [7:0]         ld_b;
  logic [15:0]        ld_h;

  logic               c_rf_wr;
  logic [RADDR_W-1:0] c_rd;
  logic [ALEN-1:0]    c_alu;

  assign mem_op  = i_mem_rd | i_mem_wr;
  assign bad_f3  = (i_funct3[1:0] == 2'b11) | (i_funct3 == 3'b110);
  assign misal   = ((i_funct3[1:0] == 2'b01) & i_alu_res[0])
                 | ((i_funct3[1:0] == 2'b10) & (|i_alu_res[1:0]));
  assign in_idle = (state == IDLE);
  assign fault   = in_idle & i_valid & mem_op & (bad_f3 | misal);
  assign nonmem  = in_idle & i_valid & ~mem_op;
  assign addr_in = {i_alu_res[ALEN-1:2], 2'b00};

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = i_store_data;
    unique case (i_funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << i_alu_res[1:0];
        wdata_in = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << {i_alu_res[1], 1'b0};
        wdata_in = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    busy         = 1'b0;
    st_done      = 1'b0;
    ld_done      = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = l_we;
    o_dmem_be    = l_be;
    o_dmem_addr  = l_addr;
    o_dmem_wdata = l_wdata;
    unique case (state)
      IDLE: begin
        issue        = i_valid & mem_op & ~fault;
        busy         = issue;
        o_dmem_req   = issue;
        o_dmem_we    = i_mem_wr;
        o_dmem_be    = be_in;
        o_dmem_addr  = addr_in;
        o_dmem_wdata = wdata_in;
        if (issue && i_dmem_gnt) begin
          st_done   = i_mem_wr;
          state_nxt = i_mem_wr ? IDLE : RESP;
        end else if (issue) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        busy       = 1'b1;
        o_dmem_req = 1'b1;
        if (i_dmem_gnt) begin
          st_done   = l_we;
          state_nxt = l_we ? IDLE : RESP;
        end
      end
      RESP: begin
        busy = 1'b1;
        if (i_dmem_rvalid) begin
          ld_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      o_dmem_req = 1'b0;
      busy       = 1'b0;
    end
  end

  assign done    = st_done | ld_done;
  assign o_stall = busy & ~done;

  // byte lane comes from the address captured at issue
  assign sh   = i_dmem_rdata >> {l_off, 3'b000};
  assign ld_b = sh[7:0];
  assign ld_h = l_off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    ld_data = i_dmem_rdata;
    unique case (l_f3)
      3'b000:  ld_data = {{(ALEN-8){ld_b[7]}}, ld_b};
      3'b100:  ld_data = {{(ALEN-8){1'b0}}, ld_b};
      3'b001:  ld_data = {{(ALEN-16){ld_h[15]}}, ld_h};
      3'b101:  ld_data = {{(ALEN-16){1'b0}}, ld_h};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  assign c_rf_wr = in_idle ? i_rf_wr      : l_rf_wr;
  assign c_rd    = in_idle ? i_rf_wr_addr : l_rd;
  assign c_alu   = in_idle ? i_alu_res    : l_alu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      l_we    <= 1'b0;
      l_rf_wr <= 1'b0;
      l_be    <= '0;
      l_off   <= '0;
      l_f3    <= '0;
      l_rd    <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_alu   <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        l_we    <= i_mem_wr;
        l_rf_wr <= i_rf_wr;
        l_be    <= be_in;
        l_off   <= i_alu_res[1:0];
        l_f3    <= i_funct3;
        l_rd    <= i_rf_wr_addr;
        l_addr  <= addr_in;
        l_wdata <= wdata_in;
        l_alu   <= i_alu_res;
      end
    end
  end

  // anything other than a retiring instruction becomes a bubble
  always_ff @(posedge clk) begin
    o_rf_wr      <= 1'b0;
    o_rf_wr_addr <= '0;
    o_rf_wr_data <= '0;
    o_mem_to_reg <= 1'b0;
    o_mem_data   <= '0;
    o_staller    <= 1'b0;
    o_fault      <= 1'b0;
    if (rst_n) begin
      if (done || nonmem) begin
        o_rf_wr      <= c_rf_wr;
        o_rf_wr_addr <= c_rd;
        o_rf_wr_data <= c_alu;
        o_mem_to_reg <= ld_done;
        o_mem_data   <= ld_done ? ld_data : '0;
        o_staller    <= ld_done;
      end else if (fault) begin
        o_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random and directed stimulus against a
// transaction-level model of the memory stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_valid, i_rf_wr, i_mem_rd, i_mem_wr;
  logic [4:0]  i_rf_wr_addr;
  logic [31:0] i_alu_res, i_store_data;
  logic [2:0]  i_funct3;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic        o_rf_wr, o_mem_to_reg, o_staller, o_fault;
  logic [4:0]  o_rf_wr_addr;
  logic [31:0] o_rf_wr_data, o_mem_data;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_rf_wr(i_rf_wr),
    .i_rf_wr_addr(i_rf_wr_addr), .i_alu_res(i_alu_res),
    .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
    .i_funct3(i_funct3), .i_store_data(i_store_data),
    .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_be(o_dmem_be),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata(i_dmem_rdata),
    .o_rf_wr(o_rf_wr), .o_rf_wr_addr(o_rf_wr_addr),
    .o_rf_wr_data(o_rf_wr_data), .o_mem_to_reg(o_mem_to_reg),
    .o_mem_data(o_mem_data), .o_staller(o_staller),
    .o_fault(o_fault)
  );

  typedef struct packed {
    logic        rf_wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        m2r;
    logic [31:0] mdata;
    logic        staller;
    logic        fault;
  } res_t;

  res_t        exp_reg = '0;
  res_t        nxt_reg = '0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        chk_on = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] a,
                       input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("stall", 32'(o_stall), 32'(exp_stall));
      check("req", 32'(o_dmem_req), 32'(exp_req));
      if (exp_req) begin
        check("we", 32'(o_dmem_we), 32'(exp_we));
        check("addr", o_dmem_addr, exp_addr);
        if (exp_we) begin
          check("be", 32'(o_dmem_be), 32'(exp_be));
          check("wdata", o_dmem_wdata, exp_wdata);
        end
      end
      check("rf_wr", 32'(o_rf_wr), 32'(exp_reg.rf_wr));
      check("rf_addr", 32'(o_rf_wr_addr), 32'(exp_reg.rd));
      check("rf_data", o_rf_wr_data, exp_reg.data);
      check("m2r", 32'(o_mem_to_reg), 32'(exp_reg.m2r));
      check("mdata", o_mem_data, exp_reg.mdata);
      check("staller", 32'(o_staller), 32'(exp_reg.staller));
      check("fault", 32'(o_fault), 32'(exp_reg.fault));
    end
  end

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_fault(input logic [2:0] f3,
                                  input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] st_be(input logic [2:0] f3,
                                       input logic [31:0] a);
    int v;
    v = ((1 << nbytes(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3,
                                          input logic [31:0] d);
    if (nbytes(f3) == 1) return (d & 32'hFF) * 32'h01010101;
    if (nbytes(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    longint m, v;
    int n;
    n = nbytes(f3);
    m = (longint'(1) << (8 * n)) - 1;
    v = (longint'(w) >> (8 * (a % 4))) & m;
    if (!f3[2] && n < 4 && v > m / 2) v = v - (m + 1);
    return v[31:0];
  endfunction

  function automatic res_t retire(input bit rd, input bit rf_wr,
                                  input logic [4:0] rda,
                                  input logic [31:0] alu,
                                  input logic [2:0] f3,
                                  input logic [31:0] w);
    res_t r;
    r.rf_wr   = rf_wr;
    r.rd      = rda;
    r.data    = alu;
    r.m2r     = rd;
    r.mdata   = rd ? ld_val(f3, alu, w) : 32'h0;
    r.staller = rd;
    r.fault   = 1'b0;
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
    exp_reg = nxt_reg;
    chk_on  = 1'b1;
  endtask

  task automatic do_instr(input bit v, input bit rd, input bit wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input bit rfw,
                          input logic [4:0] rda, input int gd,
                          input int rvd, input logic [31:0] rdata);
    i_valid      = v;
    i_mem_rd     = rd;
    i_mem_wr     = wr;
    i_funct3     = f3;
    i_alu_res    = a;
    i_store_data = sd;
    i_rf_wr      = rfw;
    i_rf_wr_addr = rda;
    exp_we       = wr;
    exp_be       = st_be(f3, a);
    exp_addr     = {a[31:2], 2'b00};
    exp_wdata    = st_data(f3, sd);
    if (!v || !(rd || wr) || is_fault(f3, a)) begin
      i_dmem_gnt    = 1'($urandom_range(0, 1));
      i_dmem_rvalid = 1'($urandom_range(0, 1));
      i_dmem_rdata  = $urandom;
      exp_stall = 1'b0;
      exp_req   = 1'b0;
      if (!v) nxt_reg = '0;
      else if (!(rd || wr)) nxt_reg = retire(0, rfw, rda, a, f3, 0);
      else begin
        nxt_reg       = '0;
        nxt_reg.fault = 1'b1;
      end
      step();
      return;
    end
    i_dmem_rvalid = 1'b0;
    for (int k = 0; k <= gd; k++) begin
      i_dmem_gnt = (k == gd);
      exp_req    = 1'b1;
      exp_stall  = wr ? (k < gd) : 1'b1;
      nxt_reg    = (wr && k == gd) ? retire(0, rfw, rda, a, f3, 0) : '0;
      step();
    end
    i_dmem_gnt = 1'b0;
    if (rd) begin
      for (int j = 1; j <= rvd; j++) begin
        i_dmem_rvalid = (j == rvd);
        i_dmem_rdata  = (j == rvd) ? rdata : $urandom;
        exp_req   = 1'b0;
        exp_stall = (j < rvd);
        nxt_reg   = (j == rvd) ? retire(1, rfw, rda, a, f3, rdata) : '0;
        step();
      end
    end
    i_dmem_rvalid = 1'b0;
  endtask

  task automatic reset_mid_load;
    do_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    i_valid = 1'b1; i_mem_rd = 1'b1; i_mem_wr = 1'b0;
    i_funct3 = 3'b010; i_alu_res = 32'h300; i_rf_wr = 1'b1;
    i_rf_wr_addr = 5'd9; i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b0;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h300;
    exp_stall = 1'b1; nxt_reg = '0;
    step();
    i_dmem_gnt = 1'b0; exp_req = 1'b0; exp_stall = 1'b1;
    step();
    rst_n = 1'b0; i_valid = 1'b0; exp_stall = 1'b0;
    step();
    rst_n = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEADBEEF;
    step();
    i_dmem_rvalid = 1'b0;
  endtask

  logic [2:0] st_f3s [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    rst_n = 1'b0;
    i_valid = 0; i_rf_wr = 0; i_mem_rd = 0; i_mem_wr = 0;
    i_rf_wr_addr = 0; i_alu_res = 0; i_store_data = 0; i_funct3 = 0;
    i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
    step();
    step();
    rst_n = 1'b1;

    check("lit_lb", ld_val(3'b000, 32'h103, 32'h80AABBCC), 32'hFFFFFF80);
    check("lit_lhu", ld_val(3'b101, 32'h106, 32'hF00D1234), 32'h0000F00D);
    check("lit_lh", ld_val(3'b001, 32'h106, 32'h8001FFFF), 32'hFFFF8001);
    check("lit_sh_be", 32'(st_be(3'b001, 32'h202)), 32'hC);
    check("lit_sh_wd", st_data(3'b001, 32'h0000BEEF), 32'hBEEFBEEF);
    check("lit_sb_be", 32'(st_be(3'b000, 32'h3)), 32'h8);
    check("lit_fault", 32'(is_fault(3'b010, 32'h101)), 32'h1);

    do_instr(1, 0, 0, 0, 32'h1234, 0, 1, 5, 0, 1, 0);
    check("add_data", o_rf_wr_data, 32'h1234);
    do_instr(1, 1, 0, 3'b000, 32'h103, 0, 1, 6, 0, 2, 32'h80AABBCC);
    check("lb_data", o_mem_data, 32'hFFFFFF80);
    do_instr(1, 0, 1, 3'b001, 32'h202, 32'h0000BEEF, 0, 0, 3, 1, 0);
    do_instr(1, 1, 0, 3'b010, 32'h101, 0, 1, 7, 0, 1, 0);
    check("lw_fault", 32'(o_fault), 32'h1);
    do_instr(1, 1, 0, 3'b101, 32'h106, 0, 1, 8, 1, 1, 32'hF00D1234);
    check("lhu_data", o_mem_data, 32'h0000F00D);
    reset_mid_load();
    do_instr(1, 0, 0, 0, 32'hCAFE, 0, 1, 3, 0, 1, 0);

    repeat (400) begin
      int k;
      bit v, rd, wr, rfw;
      logic [2:0] f3;
      logic [31:0] a;
      k   = $urandom_range(0, 9);
      v   = (k != 0);
      rd  = (k >= 1 && k <= 4);
      wr  = (k >= 5 && k <= 7);
      f3  = wr ? st_f3s[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
      rfw = wr ? 1'b0 : 1'($urandom_range(0, 1));
      do_instr(v, rd, wr, f3, a, $urandom, rfw, 5'($urandom),
               $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    end
    do_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
